// File: rtl/onchip_mem_word_fetcher_if.sv
// Command, Avalon-MM read and output stream signals of the on-chip RAM word fetcher.
// FETCH_CHECKSUM_EN adds the checksum signal to the bundle.
interface onchip_mem_word_fetcher_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic              avm_clken;
    logic [DATA_W-1:0] avm_readdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
`ifdef FETCH_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    // The fetcher side: Avalon master, command sink, stream source.
    modport master (
        input  cmd_valid, cmd_addr, cmd_count, avm_readdata, out_ready,
        output cmd_ready, busy, done, avm_address, avm_chipselect, avm_write,
        output avm_byteenable, avm_clken, out_valid, out_data, out_last
`ifdef FETCH_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_count, avm_readdata, out_ready,
        input  cmd_ready, busy, done, avm_address, avm_chipselect, avm_write,
        input  avm_byteenable, avm_clken, out_valid, out_data, out_last
`ifdef FETCH_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/onchip_mem_word_fetcher.sv
// Avalon-MM read initiator: burst of wrapping word reads from a fixed-latency RAM into a valid/ready stream.
// Optional FETCH_CHECKSUM_EN adds a running sum of the emitted words.
module onchip_mem_word_fetcher #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 8,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    onchip_mem_word_fetcher_if.master  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        remain_q, remain_d;
    logic [READ_LATENCY-1:0] strb_q, strb_d;
    logic [READ_LATENCY-1:0] slast_q, slast_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic                    done_q, done_d;

    logic [DATA_W-1:0]       data_q [FIFO_DEPTH];
    logic                    flag_q [FIFO_DEPTH];

    logic accept, credit_ok, issue, push, push_last, out_valid, pop, pop_last;

    assign accept    = bus.cmd_valid && (state_q == S_IDLE);
    // Words already in flight will land in the FIFO, so they consume credit now.
    assign credit_ok = ($countones(strb_q) + int'(occ_q)) < FIFO_DEPTH;
    assign issue     = (state_q == S_ISSUE) && credit_ok;
    assign push      = strb_q[READ_LATENCY-1];
    assign push_last = slast_q[READ_LATENCY-1];
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && bus.out_ready;
    assign pop_last  = pop && flag_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        strb_d   = READ_LATENCY'({strb_q, issue});
        slast_d  = READ_LATENCY'({slast_q, issue && (remain_q == CNT_W'(1))});
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.cmd_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_ISSUE;
                        addr_d   = bus.cmd_addr;
                        remain_d = bus.cmd_count;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The flagged word is the last one issued, so its handshake means nothing is left.
                if (pop_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            strb_q   <= '0;
            slast_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            strb_q   <= strb_d;
            slast_q  <= slast_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            done_q   <= done_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= bus.avm_readdata;
            flag_q[wr_ptr_q] <= push_last;
        end
    end

`ifdef FETCH_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = '0;
        end else if (pop) begin
            sum_d = sum_q + data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.checksum = sum_q;
`endif

    assign bus.cmd_ready      = (state_q == S_IDLE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = done_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = issue;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_byteenable = 4'hF;
    assign bus.avm_clken      = 1'b1;
    assign bus.out_valid      = out_valid;
    assign bus.out_data       = out_valid ? data_q[rd_ptr_q] : '0;
    assign bus.out_last       = out_valid && flag_q[rd_ptr_q];
endmodule

// File: tb/tb_onchip_mem_word_fetcher.sv
// Scoreboard bench for onchip_mem_word_fetcher: expected addresses and stream words are queued at
// command issue; a negedge monitor checks them as the DUT presents them.
module tb_onchip_mem_word_fetcher;
    logic clk;
    logic rst;

    onchip_mem_word_fetcher_if #(.ADDR_W(2), .DATA_W(32), .CNT_W(8)) bus ();

    onchip_mem_word_fetcher #(
        .ADDR_W(2), .DATA_W(32), .CNT_W(8), .READ_LATENCY(1), .FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [4];
    logic [31:0] rd_q;

    // Single-cycle-latency RAM slave.
    always @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else if (bus.avm_chipselect && !bus.avm_write) rd_q <= mem[bus.avm_address];
    end
    assign bus.avm_readdata = rd_q;

    int compared   = 0;
    int mismatched = 0;

    logic [32:0] exp_q    [$];
    logic [1:0]  exp_addr [$];

    int  cs_cnt, pop_cnt, done_cnt;
    bit  seen_valid, hold_pending, throttle;
    time first_valid_t, done_t, ta;
    logic [33:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.avm_chipselect) begin
                cs_cnt++;
                if (exp_addr.size() == 0) check("unexpected_read", 64'(bus.avm_address), 64'hDEAD);
                else check("avm_address", 64'(bus.avm_address), 64'(exp_addr.pop_front()));
            end
            if (bus.out_valid && !seen_valid) begin
                seen_valid    = 1'b1;
                first_valid_t = $time;
            end
            if (hold_pending)
                check("stall_hold", 64'({bus.out_valid, bus.out_last, bus.out_data}), 64'(held));
            hold_pending = bus.out_valid && !bus.out_ready;
            held         = {1'b1, bus.out_last, bus.out_data};
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) check("unexpected_word", 64'({bus.out_last, bus.out_data}), 64'hDEAD);
                else check("stream_word", 64'({bus.out_last, bus.out_data}), 64'(exp_q.pop_front()));
            end
            if (bus.done) begin
                done_cnt++;
                done_t = $time;
            end
        end
    end

    always @(posedge clk) begin
        if (throttle) begin
            #1;
            bus.out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Called just after a posedge; returns just after the acceptance edge.
    task automatic start_cmd(input logic [1:0] a, input int c);
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        cs_cnt = 0; pop_cnt = 0; done_cnt = 0; seen_valid = 1'b0;
        for (int i = 0; i < c; i++) begin
            exp_addr.push_back(2'((int'(a) + i) % 4));
            exp_q.push_back({(i == c - 1), mem[(int'(a) + i) % 4]});
        end
        bus.cmd_addr  = a;
        bus.cmd_count = 8'(c);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        ta = $time;
        #1 bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 2'd0;
        bus.cmd_count = 8'd0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) check({name, "_timeout"}, 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, "_drained"}, 64'(exp_q.size() + exp_addr.size()), 64'd0);
    endtask

    initial begin
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        throttle = 1'b0; hold_pending = 1'b0;
        cs_cnt = 0; pop_cnt = 0; done_cnt = 0; seen_valid = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_count = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        #2;
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_outputs", 64'({bus.busy, bus.done, bus.out_valid, bus.out_last, bus.avm_chipselect, bus.avm_write}), 64'd0);
        check("rst_ties", 64'({bus.avm_byteenable, bus.avm_clken}), 64'h1F);
        check("rst_data", 64'(bus.out_data), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: aligned 4-word fetch, latency and done timing
        start_cmd(2'd0, 4);
        wait_done("t1");
        check("t1_first_valid_cycle", 64'(first_valid_t - ta), 64'd25);
        check("t1_done_cycle", 64'(done_t - ta), 64'd65);
        check("t1_reads", 64'(cs_cnt), 64'd4);
`ifdef FETCH_CHECKSUM_EN
        check("t1_checksum", 64'(bus.checksum), 64'hAAAAAAAA);
`endif

        // 2: address wrap
        start_cmd(2'd3, 6);
        wait_done("t2");
        check("t2_reads", 64'(cs_cnt), 64'd6);

        // 3: sink stalled; a 6-word command must stop issuing once FIFO credit is used up
        bus.out_ready = 1'b0;
        start_cmd(2'd0, 6);
        repeat (10) @(posedge clk);
        #1;
        check("t3_reads_stalled", 64'(cs_cnt), 64'd4);
        check("t3_valid_stalled", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        wait_done("t3");
        check("t3_reads_total", 64'(cs_cnt), 64'd6);

        // 4: zero-length command
        start_cmd(2'd2, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t4_done_cycle", 64'(done_t - ta), 64'd5);
        check("t4_done_pulses", 64'(done_cnt), 64'd1);
        check("t4_reads", 64'(cs_cnt), 64'd0);
        check("t4_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // 5: reset in the middle of an 8-word command
        start_cmd(2'd0, 8);
        for (int n = 0; n < 50 && pop_cnt < 2; n++) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_popped_before_reset", 64'(pop_cnt), 64'd2);
        check("t5_rst_outputs", 64'({bus.busy, bus.done, bus.out_valid, bus.avm_chipselect}), 64'd0);
        check("t5_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        exp_q.delete();
        exp_addr.delete();
        hold_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_done", 64'(done_cnt), 64'd0);
        start_cmd(2'd1, 2);
        wait_done("t5");
        check("t5_words_after", 64'(pop_cnt), 64'd2);

        // 6: random output throttling keeps order, last flag and sum
        throttle = 1'b1;
        start_cmd(2'd0, 4);
        wait_done("t6");
        throttle = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
`ifdef FETCH_CHECKSUM_EN
        check("t6_checksum", 64'(bus.checksum), 64'hAAAAAAAA);
`endif
        check("t6_words", 64'(pop_cnt), 64'd4);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
